// File: rtl/input_dma_controller_if.sv
// input_dma_controller_if: AXI4 read address/data channels between the DMA (master) and the interconnect (slave)
interface input_dma_controller_if;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  modport master (output araddr, arlen, arsize, arburst, arvalid, rready,
                  input  arready, rdata, rresp, rlast, rvalid);
  modport slave  (input  araddr, arlen, arsize, arburst, arvalid, rready,
                  output arready, rdata, rresp, rlast, rvalid);
endinterface

// File: rtl/input_dma_controller.sv
// input_dma_controller: AXI4 read-burst DMA into a byte-wide BRAM; define INPUT_DMA_4K_SPLIT_EN to split bursts at 4 KB boundaries
module input_dma_controller #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 8,
  parameter int MAX_BURST_BEATS = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [15:0]           byte_count,
  output logic                  done,
  output logic                  busy,
  output logic                  error,
  output logic                  data_ready,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic                  bram_we,
  output logic [DATA_WIDTH-1:0] bram_wdata,
  input_dma_controller_if.master axi
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;
  localparam logic [15:0] MAXB = 16'(MAX_BURST_BEATS);
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ext_q, ext_d, baddr_q, baddr_d;
  logic [15:0]           beats_q, beats_d, bytes_q, bytes_d, burst;
  logic [8:0]            left_q, left_d;
  logic [31:0]           buf_q, buf_d;
  logic [2:0]            cnt_q, cnt_d, take;
  logic                  last_q, last_d, err_q, err_d, dr_q, dr_d, r_hs, bad;
`ifdef INPUT_DMA_4K_SPLIT_EN
  logic [15:0]           lim;
`endif
  always_comb begin
    burst = beats_q > MAXB ? MAXB : beats_q;
`ifdef INPUT_DMA_4K_SPLIT_EN
    lim   = 16'((13'h1000 - {1'b0, ext_q[11:0]}) >> 2);
    burst = burst > lim ? lim : burst;
`endif
  end
  assign axi.arsize  = 3'b010;
  assign axi.arburst = 2'b01;
  assign axi.arvalid = state_q == ADDR;
  assign axi.araddr  = 32'(ext_q);
  assign axi.arlen   = state_q == ADDR ? 8'(burst - 16'd1) : 8'd0;
  // Accept the next beat while the last buffered byte is on the BRAM port; after an error just drain to rlast
  assign axi.rready  = state_q == DATA && (err_q || (!last_q && cnt_q <= 3'd1));
  assign bram_we     = state_q == DATA && cnt_q != 3'd0 && !err_q;
  assign bram_addr   = baddr_q;
  assign bram_wdata  = DATA_WIDTH'(buf_q[7:0]);
  assign done        = state_q == DONE;
  assign busy        = state_q == ADDR || state_q == DATA;
  assign error       = err_q;
  assign data_ready  = dr_q;
  assign r_hs        = axi.rvalid && axi.rready;
  assign bad         = axi.rresp != 2'b00 || axi.rlast != (left_q == 9'd1);
  assign take        = bytes_q >= 16'd4 ? 3'd4 : bytes_q[2:0];
  always_comb begin
    state_d = state_q;
    ext_d   = ext_q;
    baddr_d = baddr_q;
    beats_d = beats_q;
    bytes_d = bytes_q;
    left_d  = left_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    err_d   = err_q;
    dr_d    = dr_q;
    case (state_q)
      IDLE: if (start) begin
        if (byte_count == 16'd0) begin
          state_d = DONE;
          err_d   = 1'b0;
          dr_d    = 1'b1;
        end else if (src_addr[1:0] != 2'b00) begin
          state_d = DONE;
          err_d   = 1'b1;
          dr_d    = 1'b0;
        end else begin
          state_d = ADDR;
          ext_d   = src_addr;
          baddr_d = dst_addr;
          beats_d = 16'((17'(byte_count) + 17'd3) >> 2);
          bytes_d = byte_count;
          cnt_d   = 3'd0;
          last_d  = 1'b0;
          err_d   = 1'b0;
          dr_d    = 1'b0;
        end
      end
      ADDR: if (axi.arready) begin
        state_d = DATA;
        ext_d   = ext_q + ADDR_WIDTH'({burst, 2'b00});
        beats_d = beats_q - burst;
        left_d  = burst[8:0];
        last_d  = 1'b0;
      end
      DATA: begin
        if (bram_we) begin
          buf_d   = buf_q >> 8;
          cnt_d   = cnt_q - 3'd1;
          baddr_d = baddr_q + 1'b1;
        end
        if (r_hs) begin
          left_d = left_q - 9'd1;
          if (err_q || bad) begin
            err_d   = 1'b1;
            cnt_d   = 3'd0;
            state_d = axi.rlast ? DONE : DATA;
          end else begin
            buf_d   = axi.rdata;
            cnt_d   = take;
            bytes_d = bytes_q - 16'(take);
            last_d  = axi.rlast;
          end
        end else if (!err_q && last_q && cnt_q <= 3'd1) begin
          state_d = beats_q != 16'd0 ? ADDR : DONE;
          dr_d    = beats_q == 16'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ext_q   <= '0;
      baddr_q <= '0;
      beats_q <= '0;
      bytes_q <= '0;
      left_q  <= '0;
      buf_q   <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      dr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ext_q   <= ext_d;
      baddr_q <= baddr_d;
      beats_q <= beats_d;
      bytes_q <= bytes_d;
      left_q  <= left_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      err_q   <= err_d;
      dr_q    <= dr_d;
    end
  end
endmodule

// File: doc/input_dma_controller.md
# input_dma_controller

Reads layer inputs (weights/activations) from external memory over AXI4 read bursts and writes them byte-by-byte into the BRAM activation buffer. It is the read-side counterpart of the output DMA and sits between the AXI interconnect and the layer compute unit's input BRAM. One start pulse moves `byte_count` bytes from external `src_addr` to BRAM `dst_addr`, splitting the transfer into bursts as needed.

## Interface
- `ADDR_WIDTH`, 32, width of BRAM address and external address
- `DATA_WIDTH`, 8, BRAM write data width (byte-oriented)
- `MAX_BURST_BEATS`, 256, maximum beats per AR request (1..256)

- `clk`  in  1  clock; one clock, all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `start`  in  1  start pulse, sampled in IDLE only
- `src_addr`  in  ADDR_WIDTH  external byte address, must be 4-byte aligned
- `dst_addr`  in  ADDR_WIDTH  BRAM byte start address
- `byte_count`  in  16  bytes to transfer
- `done`  out  1  one-cycle completion pulse (success or error)
- `busy`  out  1  high while transfer in progress
- `error`  out  1  held high from error detection until next accepted start
- `data_ready`  out  1  high after successful completion until next accepted start
- `bram_addr`  out  ADDR_WIDTH  BRAM write address
- `bram_we`  out  1  BRAM byte write enable
- `bram_wdata`  out  DATA_WIDTH  BRAM write data
- `araddr` out 32, `arlen` out 8, `arsize` out 3 (fixed 3'b010), `arburst` out 2 (fixed 2'b01 INCR), `arvalid` out 1, `arready` in 1: AXI4 read address channel
- `rdata` in 32, `rresp` in 2, `rlast` in 1, `rvalid` in 1, `rready` out 1: AXI4 read data channel

## Operation
- States: IDLE, ADDR, DATA, DONE.
- IDLE: on `start`: `byte_count==0` -> DONE, no AXI traffic, `data_ready` set; `src_addr[1:0]!=0` -> set `error`, DONE, no AXI traffic; else latch addresses, beats_remaining = (byte_count+3)>>2, bytes_remaining = byte_count, clear `error`/`data_ready`, -> ADDR.
- ADDR: `arvalid`=1; burst_beats = min(beats_remaining, MAX_BURST_BEATS); `arlen`=burst_beats-1. `araddr`/`arlen` stable until `arready`. On handshake: ext addr += burst_beats*4, beats_remaining -= burst_beats, -> DATA.
- DATA: `rready` = word buffer empty. On R handshake load buffer; byte order little-endian (rdata[7:0] first). Bytes written one per cycle, `bram_addr` incrementing from `dst_addr`; bytes beyond bytes_remaining in the last beat are discarded (no write).
- Burst end on `rlast` handshake with buffer drained: beats_remaining>0 -> ADDR; else -> DONE.
- `rresp` != OKAY on any beat: set `error`, suppress all further BRAM writes, keep `rready`=1 until `rlast` of that burst, then DONE. `rlast` early or missing on expected last beat: same error handling.
- DONE: `done`=1 one cycle, `busy`=0, -> IDLE. `data_ready` set iff no error.
- `start` while not IDLE ignored.

## Timing
- Reset values: all outputs 0 (`arsize`/`arburst` constant); state IDLE.
- `arvalid` asserted the cycle after accepted `start`.
- R handshake at edge k: byte0 on `bram_we/addr/wdata` in cycle after k; bytes 1..3 in the following three cycles; `rready` reasserted in the cycle byte3 is presented. Sustained rate 1 byte/cycle.
- Next AR issued the cycle after the final beat's last byte cycle.
- `done` pulses the cycle after the last `bram_we` cycle (or the cycle after `start` for zero-length/misaligned).
- `busy` high from cycle after accepted `start` through the cycle before `done`.
- `rst` mid-transfer: immediate return to IDLE, `arvalid`/`rready`/`bram_we` low next cycle; outstanding AXI transaction abandoned (interconnect reset by same `rst`).

## Configuration
- `INPUT_DMA_4K_SPLIT_EN`: defined -> burst_beats additionally limited to (4096 - ext_addr[11:0])>>2 so no burst crosses a 4 KB boundary. Undefined -> limit is beats_remaining and MAX_BURST_BEATS only; caller guarantees no crossing.

## Test plan
- src 0x1000, dst 0x0, 16 bytes, zero-wait slave -> one AR arlen=3, BRAM 0..15 written in order, 16 consecutive `bram_we` cycles, `done` pulse, `data_ready`=1.
- 10 bytes from 0x2000 -> arlen=2, exactly 10 writes, bytes 2,3 of beat 2 discarded.
- 1100 bytes, MAX_BURST_BEATS=256 -> ARs arlen=255 at 0x0, arlen=18 at 0x400; 1100 writes; random `arready`/`rvalid` stalls give identical BRAM contents.
- SLVERR on beat 1 of 4-beat burst -> only beat 0 (4 bytes) written, `rready` held until `rlast`, `error`=1, `done` pulse, `data_ready`=0.
- `byte_count`=0 -> `done` next cycle, no `arvalid`; misaligned src 0x1001 -> `error`=1, `done`, no AXI traffic.
- With `INPUT_DMA_4K_SPLIT_EN`, src 0x0FF0, 32 bytes -> two ARs (0x0FF0 arlen=3, 0x1000 arlen=3); `rst` during second burst -> all outputs 0 next cycle, state IDLE.
